// File: rtl/serdesphy_rx_pkg.sv
// Shared definitions for the SerDes PHY RX word aligner.
//   align_state_e     : alignment state encoding as seen on align_state
//   SYNC_W            : width of the frame sync word in bits
//   DEFAULT_SYNC_WORD : default frame sync pattern (MSB received first)
package serdesphy_rx_pkg;

  localparam int SYNC_W = 8;
  localparam logic [SYNC_W-1:0] DEFAULT_SYNC_WORD = 8'hA5;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } align_state_e;

endpackage

// File: rtl/serdesphy_rx_word_aligner.sv
// RX word aligner: finds the periodic sync word in the recovered serial bit
// stream, tracks frame alignment with HUNT/VERIFY/LOCKED hysteresis and emits
// aligned 4-bit payload nibbles towards the RX FIFO.
//
// Ports:
//   clk_240m_rx      in   RX bit clock
//   rst_240m_rx      in   synchronous active-high reset
//   rx_en            in   block enable; low acts like rx_align_rst
//   rx_align_rst     in   synchronous re-hunt request (keeps frame_err_cnt)
//   rx_serial_data   in   serial bit
//   rx_serial_valid  in   bit qualifier
//   rx_serial_error  in   marks the accepted bit as suspect
//   rx_nibble        out  aligned payload nibble, first-received bit in [3]
//   rx_nibble_valid  out  one-cycle strobe per nibble
//   rx_nibble_err    out  a bit of the presented nibble was flagged
//   rx_aligned       out  high while LOCKED
//   align_state      out  current state (00 HUNT, 01 VERIFY, 10 LOCKED)
//   align_lost       out  one-cycle pulse on LOCKED -> HUNT
//   frame_err_cnt    out  saturating count of missed syncs while LOCKED
//
// Handshake: the input side is valid-only (no backpressure); a bit is taken
// on every clock where rx_serial_valid & rx_en is high. The output side is a
// one-cycle rx_nibble_valid strobe; the consumer must always accept it.
module serdesphy_rx_word_aligner
  import serdesphy_rx_pkg::*;
#(
  parameter logic [SYNC_W-1:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
  parameter int                FRAME_BITS = 64,
  parameter int                VERIFY_CNT = 2,
  parameter int                LOSS_CNT   = 3
) (
  input  logic       clk_240m_rx,
  input  logic       rst_240m_rx,
  input  logic       rx_en,
  input  logic       rx_align_rst,
  input  logic       rx_serial_data,
  input  logic       rx_serial_valid,
  input  logic       rx_serial_error,
  output logic [3:0] rx_nibble,
  output logic       rx_nibble_valid,
  output logic       rx_nibble_err,
  output logic       rx_aligned,
  output logic [1:0] align_state,
  output logic       align_lost,
  output logic [7:0] frame_err_cnt
);

  localparam int BC_W = $clog2(FRAME_BITS);
  localparam int MC_W = $clog2(VERIFY_CNT + 1);
  localparam int LC_W = $clog2(LOSS_CNT + 1);
  localparam logic [BC_W-1:0] BC_LAST    = BC_W'(FRAME_BITS - 1);
  localparam logic [BC_W-1:0] BC_PAYLOAD = BC_W'(FRAME_BITS - SYNC_W);
  localparam logic [MC_W-1:0] MC_DONE    = MC_W'(VERIFY_CNT);
  localparam logic [LC_W-1:0] LC_DONE    = LC_W'(LOSS_CNT);

  align_state_e      r_state;
  logic [SYNC_W-2:0] r_sr;  // only 7 history bits are needed; the new bit completes the window
  logic [BC_W-1:0]   r_bit_cnt;
  logic [MC_W-1:0]   r_match_cnt;
  logic [LC_W-1:0]   r_miss_cnt;
  logic              r_err_acc;
  logic [7:0]        r_frame_err_cnt;
  logic [3:0]        r_nibble;
  logic              r_nibble_valid;
  logic              r_nibble_err;
  logic              r_align_lost;

  logic              w_accept;
  logic              w_clear;
  logic [SYNC_W-1:0] w_sr_next;
  logic              w_sync_hit;
  logic              w_boundary;
  logic              w_payload;
  logic [BC_W-1:0]   w_bit_cnt_inc;
  align_state_e      w_state_next;
  logic [BC_W-1:0]   w_bit_cnt_next;
  logic [MC_W-1:0]   w_match_next;
  logic [LC_W-1:0]   w_miss_next;
  logic              w_frame_miss;
  logic              w_lost;
  logic              w_nib_emit;

  assign w_accept      = rx_serial_valid & rx_en;
  assign w_clear       = rx_align_rst | ~rx_en;
  assign w_sr_next     = {r_sr, rx_serial_data};
  assign w_sync_hit    = (w_sr_next == SYNC_WORD);
  assign w_boundary    = (r_bit_cnt == BC_LAST);
  assign w_payload     = (r_bit_cnt < BC_PAYLOAD);
  assign w_bit_cnt_inc = w_boundary ? '0 : r_bit_cnt + BC_W'(1);

  // Next-state and counter updates; nothing moves without an accepted bit.
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_match_next   = r_match_cnt;
    w_miss_next    = r_miss_cnt;
    w_frame_miss   = 1'b0;
    w_lost         = 1'b0;
    w_nib_emit     = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_HUNT: begin
          if (w_sync_hit) begin
            w_state_next   = ST_VERIFY;
            w_bit_cnt_next = '0;
            w_match_next   = '0;
          end
        end
        ST_VERIFY: begin
          w_bit_cnt_next = w_bit_cnt_inc;
          if (w_boundary) begin
            if (w_sync_hit) begin
              w_match_next = r_match_cnt + MC_W'(1);
              if (w_match_next == MC_DONE) begin
                w_state_next = ST_LOCKED;
                w_miss_next  = '0;
              end
            end else begin
              // The failing bit is not rescanned for a fresh sync.
              w_state_next = ST_HUNT;
            end
          end
        end
        ST_LOCKED: begin
          w_bit_cnt_next = w_bit_cnt_inc;
          w_nib_emit     = w_payload && (r_bit_cnt[1:0] == 2'b11);
          if (w_boundary) begin
            if (w_sync_hit) begin
              w_miss_next = '0;
            end else begin
              w_frame_miss = 1'b1;
              w_miss_next  = r_miss_cnt + LC_W'(1);
              if (w_miss_next == LC_DONE) begin
                w_state_next = ST_HUNT;
                w_lost       = 1'b1;
              end
            end
          end
        end
        default: w_state_next = ST_HUNT;
      endcase
    end
  end

  // State register; reset and re-hunt both win over a simultaneous bit.
  always_ff @(posedge clk_240m_rx) begin
    if (rst_240m_rx || w_clear) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_240m_rx) begin
    if (rst_240m_rx || w_clear) begin
      r_sr           <= '0;
      r_bit_cnt      <= '0;
      r_match_cnt    <= '0;
      r_miss_cnt     <= '0;
      r_err_acc      <= 1'b0;
      r_nibble       <= '0;
      r_nibble_valid <= 1'b0;
      r_nibble_err   <= 1'b0;
      r_align_lost   <= 1'b0;
    end else begin
      r_bit_cnt      <= w_bit_cnt_next;
      r_match_cnt    <= w_match_next;
      r_miss_cnt     <= w_miss_next;
      r_nibble_valid <= w_nib_emit;
      r_nibble       <= w_nib_emit ? w_sr_next[3:0] : 4'h0;
      r_nibble_err   <= w_nib_emit & (r_err_acc | rx_serial_error);
      r_align_lost   <= w_lost;
      if (w_accept) begin
        r_sr <= w_sr_next[SYNC_W-2:0];
      end
      // Error flags only matter on LOCKED payload bits; cleared per nibble.
      if (w_accept && (r_state == ST_LOCKED) && w_payload) begin
        r_err_acc <= w_nib_emit ? 1'b0 : (r_err_acc | rx_serial_error);
      end
    end
  end

  // Miss counter survives re-hunt; only the block reset clears it.
  always_ff @(posedge clk_240m_rx) begin
    if (rst_240m_rx) begin
      r_frame_err_cnt <= '0;
    end else if (!w_clear && w_frame_miss && (r_frame_err_cnt != 8'hFF)) begin
      r_frame_err_cnt <= r_frame_err_cnt + 8'd1;
    end
  end

  assign rx_nibble       = r_nibble;
  assign rx_nibble_valid = r_nibble_valid;
  assign rx_nibble_err   = r_nibble_err;
  assign rx_aligned      = (r_state == ST_LOCKED);
  assign align_state     = r_state;
  assign align_lost      = r_align_lost;
  assign frame_err_cnt   = r_frame_err_cnt;

endmodule
